// File: rtl/serial_adder.sv
// Bit-serial adder: a single full-adder cell with a carry flop walks the operands LSB-first,
// taking WIDTH cycles per addition and publishing {cout,sum} only once the last bit is done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (c & (x ^ y));
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             bit_sum_s;
    logic             bit_carry_s;
    logic             last_bit_s;

    // Full-adder cell on the current operand LSBs and the carry flop
    always_comb begin
        bit_sum_s   = fa_sum(a_r[0], b_r[0], carry_r);
        bit_carry_s = fa_carry(a_r[0], b_r[0], carry_r);
        last_bit_s  = (cnt_r == CW'(WIDTH - 1));
    end

    // Control FSM and datapath registers; outputs update only when DONE is entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    res_r   <= {bit_sum_s, res_r[WIDTH-1:1]};
                    carry_r <= bit_carry_s;
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        // The final sum bit is folded in directly so the result lands this edge
                        sum_r   <= {bit_sum_s, res_r[WIDTH-1:1]};
                        cout_r  <= bit_carry_s;
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases, held-start streaming,
// mid-operation reset and a randomized regression against an arithmetic reference.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[8:0];
    endfunction

    // Issue one start pulse, scramble the operands afterwards, and wait for done.
    // lat = cycle index (1 = cycle after the accept edge) in which done was seen.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          output int lat, output int busy_cnt, output int overlap);
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        lat = 1; busy_cnt = 0; overlap = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
            if (busy === 1'b1 && done === 1'b1) overlap++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sum, cout, busy, done} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state: got sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] op_a [4] = '{8'h00, 8'hFF, 8'h3C, 8'hA5};
        logic [7:0] op_b [4] = '{8'h00, 8'h01, 8'h42, 8'h5A};
        logic       op_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] exp;
        logic [7:0] held;
        int lat, bc, ov;
        for (int i = 0; i < 4; i++) begin
            exp = ref_add(op_a[i], op_b[i], op_c[i]);
            run_op(op_a[i], op_b[i], op_c[i], lat, bc, ov);
            checks++;
            if (lat != 9) begin
                failures++;
                $display("FAIL directed_latency[%0d]: done at cycle %0d, want 9", i, lat);
            end
            checks++;
            if ({cout, sum} !== exp) begin
                failures++;
                $display("FAIL directed_result[%0d]: got cout=%b sum=%h, want cout=%b sum=%h",
                         i, cout, sum, exp[8], exp[7:0]);
            end
            checks++;
            if (bc != 8 || ov != 0) begin
                failures++;
                $display("FAIL directed_busy[%0d]: busy cycles=%0d overlap=%0d, want 8 and 0", i, bc, ov);
            end
        end
        // Idle with start low: result must hold while inputs wander
        held = sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if (sum !== held || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got sum=%h busy=%b done=%b, want sum=%h busy=0 done=0", sum, busy, done, held);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fa = 8'h9D;
        logic [7:0] fb = 8'h77;
        logic       fc = 1'b1;
        logic [8:0] exp;
        int last_done = -1;
        int busy_run = 0;
        int ndone = 0;
        exp = ref_add(fa, fb, fc);
        @(negedge clk);
        a = fa; b = fb; cin = fc; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && done === 1'b1) begin
                checks++; failures++;
                $display("FAIL b2b_overlap: busy and done both high at cycle %0d", i);
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if ({cout, sum} !== exp) begin
                    failures++;
                    $display("FAIL b2b_result: got cout=%b sum=%h, want cout=%b sum=%h", cout, sum, exp[8], exp[7:0]);
                end
                if (last_done >= 0) begin
                    checks++;
                    if (i - last_done != 10 || busy_run != 8) begin
                        failures++;
                        $display("FAIL b2b_period: spacing=%0d busy=%0d, want 10 and 8", i - last_done, busy_run);
                    end
                end
                last_done = i;
                busy_run = 0;
            end else if (busy === 1'b1) begin
                busy_run++;
            end
            if (busy === 1'b1) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end else begin
                a = fa; b = fb; cin = fc;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone < 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses in 40 cycles, want at least 3", ndone);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        int lat, bc, ov;
        logic [8:0] exp;
        @(negedge clk);
        a = 8'h3C; b = 8'h42; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({sum, cout, busy, done} !== 11'd0) begin
            failures++;
            $display("FAIL abort_state: got sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d busy/done cycles after abort, want 0", seen);
        end
        exp = ref_add(8'hC3, 8'h5E, 1'b1);
        run_op(8'hC3, 8'h5E, 1'b1, lat, bc, ov);
        checks++;
        if (lat != 9 || {cout, sum} !== exp) begin
            failures++;
            $display("FAIL abort_restart: got lat=%0d cout=%b sum=%h, want lat=9 cout=%b sum=%h",
                     lat, cout, sum, exp[8], exp[7:0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp;
        int lat, bc, ov;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, lat, bc, ov);
            checks++;
            if (lat != 9 || {cout, sum} !== exp) begin
                failures++;
                $display("FAIL random[%0d]: a=%h b=%h cin=%b got lat=%0d cout=%b sum=%h, want lat=9 cout=%b sum=%h",
                         n, ra, rb, rc, lat, cout, sum, exp[8], exp[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 Port: sum  output  WIDTH  registered result of a+b+cin, low WIDTH bits.
REQ-009 Port: cout  output  1  registered carry-out of the addition.
REQ-010 Port: busy  output  1  high while bits are being shifted (state SHIFT).
REQ-011 Port: done  output  1  one-cycle pulse; sum/cout valid from this cycle onward.

Function
REQ-012 Architecture: one 1-bit full-adder cell (sum = x^y^c, carry = x&y | c&(x^y)), a carry flip-flop, two operand shift registers, a result shift register and a bit counter; processing is LSB-first.
REQ-013 FSM states: IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE -> SHIFT on a rising edge with start=1: load a and b into the shift registers, load cin into the carry flip-flop, clear the bit counter.
REQ-015 IDLE with start=0: hold state; sum and cout keep their last values.
REQ-016 SHIFT: each edge adds the current LSBs with the carry flop, shifts the sum bit into the result register MSB-side, stores the new carry, shifts both operands right and increments the counter.
REQ-017 SHIFT -> DONE on the edge that processes bit WIDTH-1 (exactly WIDTH SHIFT edges); on that edge sum is loaded with the completed result and cout with the final carry.
REQ-018 DONE -> IDLE unconditionally on the next edge.
REQ-019 Latency: with start accepted at edge k, done=1 during the cycle after edge k+WIDTH; busy=1 during the cycles after edges k through k+WIDTH-1.
REQ-020 done and busy are registered and decoded from state only; they are never high simultaneously.
REQ-021 start is ignored in SHIFT and DONE; a start held continuously is re-accepted at the first IDLE edge, giving back-to-back operations every WIDTH+2 cycles.
REQ-022 Operand changes on a/b/cin after the accepted start edge do not affect the result in progress.
REQ-023 sum and cout change only on the DONE-entry edge or on reset; intermediate partial sums are never visible on them.
REQ-024 Arithmetic: {cout,sum} equals the (WIDTH+1)-bit value a+b+cin, with wrap-around in sum and overflow in cout.

Reset
REQ-025 On a rising edge with rst_n=0: state=IDLE, sum=0, cout=0, busy=0, done=0, counter, carry flop and shift registers cleared.
REQ-026 Reset takes priority over start and over any state transition.
REQ-027 Reset asserted mid-SHIFT aborts the operation; no done pulse is issued for it, and sum/cout read 0.
REQ-028 The first edge after rst_n returns to 1 behaves as IDLE and may accept start.

Verification (WIDTH=8)
REQ-029 a=0x00, b=0x00, cin=0, start pulse -> done exactly 9 cycles after the start edge, sum=0x00, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
REQ-031 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; carry-in propagates through all 8 bits.
REQ-032 start held high for 30 cycles with fixed operands -> done pulses every 10 cycles, busy high exactly 8 cycles per operation, and changing a/b during busy leaves the result unchanged.
REQ-033 rst_n=0 for one edge during the 4th SHIFT cycle -> no done, sum=0x00, cout=0, busy=0; a fresh start then completes correctly 9 cycles later.
REQ-034 Random regression (>=1000 operations, random cin) -> every {cout,sum} equals a+b+cin, checked on the done cycle.
